// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared types and default geometry for the frame-buffer
//               scheduler (state encoding, VGA window offsets, frame size)
//               plus a constant-by-variable shift-add multiply helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_WAIT_SOF = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_HOLD     = 3'd4
  } fb_state_e;

  localparam int         FB_FRAME_W      = 640;
  localparam int         FB_FRAME_H      = 480;
  localparam int         FB_ADDR_W       = 19;
  localparam int         FB_H_OFFSET     = 144;
  localparam int         FB_V_OFFSET     = 35;
  localparam logic [7:0] FB_CLEAR_VALUE  = 8'd244;
  localparam int         FB_FRAME_PIXELS = FB_FRAME_W * FB_FRAME_H;
  localparam int         FB_COORD_W      = 11;

  // k is always a constant at the call site, so the loop folds into a sum of
  // shifted copies of v (640 -> (v<<9) + (v<<7)), no multiplier needed.
  function automatic logic [31:0] mul_const(input logic [31:0] k,
                                            input logic [FB_COORD_W-1:0] v);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + ({{(32-FB_COORD_W){1'b0}}, v} << i);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_rd_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fb_rd_addr_gen
// Description : Converts VGA beam coordinates into a linear frame-buffer read
//               address, one registered stage; rd_addr holds while the beam
//               is outside the visible area and out-of-frame results read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_rd_addr_gen
  import fb_pkg::*;
#(
  parameter int FRAME_W  = FB_FRAME_W,
  parameter int FRAME_H  = FB_FRAME_H,
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int H_OFFSET = FB_H_OFFSET,
  parameter int V_OFFSET = FB_V_OFFSET
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  vga_active_i,
  input  logic [FB_COORD_W-1:0] vga_x_i,
  input  logic [FB_COORD_W-1:0] vga_y_i,
  output logic                  rd_en_o,
  output logic [ADDR_W-1:0]     rd_addr_o
);

  localparam logic [31:0]           c_frame_w = 32'(FRAME_W);
  localparam logic [31:0]           c_pixels  = 32'(FRAME_W * FRAME_H);
  localparam logic [FB_COORD_W-1:0] c_h_off   = FB_COORD_W'(H_OFFSET);
  localparam logic [FB_COORD_W-1:0] c_v_off   = FB_COORD_W'(V_OFFSET);

  logic [FB_COORD_W-1:0] w_dx;
  logic [FB_COORD_W-1:0] w_dy;
  logic [31:0]           w_lin;
  logic [ADDR_W-1:0]     w_addr;
  logic                  rd_en_q;
  logic [ADDR_W-1:0]     rd_addr_q;

  // Window-relative coordinates and linear address; anything past the last
  // pixel (bad VGA timing) is steered to address 0 rather than wrapping.
  always_comb begin
    w_dx   = vga_x_i - c_h_off;
    w_dy   = vga_y_i - c_v_off;
    w_lin  = mul_const(c_frame_w, w_dy) + {{(32-FB_COORD_W){1'b0}}, w_dx};
    w_addr = (w_lin >= c_pixels) ? '0 : w_lin[ADDR_W-1:0];
  end

  // Register enable every cycle; address only updates while the beam is visible
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_en_q <= vga_active_i;
      if (vga_active_i) rd_addr_q <= w_addr;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;

endmodule
`default_nettype wire

// File: rtl/fb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fb_scheduler
// Description : Frame-buffer controller. Clears the RAM after start, then
//               captures camera frames aligned to VSYNC, holds the image when
//               capture_en drops, and maps VGA coordinates to read addresses.
//               Optional build macro FB_TEST_PATTERN_EN replaces captured
//               pixel data with (pixel counter ^ frame counter).
// Revision    : 1.0 - initial release
// ============================================================================
module fb_scheduler
  import fb_pkg::*;
#(
  parameter int         FRAME_W     = FB_FRAME_W,
  parameter int         FRAME_H     = FB_FRAME_H,
  parameter int         ADDR_W      = FB_ADDR_W,
  parameter logic [7:0] CLEAR_VALUE = FB_CLEAR_VALUE,
  parameter int         H_OFFSET    = FB_H_OFFSET,
  parameter int         V_OFFSET    = FB_V_OFFSET
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  capture_en,
  input  logic                  cam_frame_start,
  input  logic                  cam_valid,
  input  logic [7:0]            cam_data,
  input  logic                  vga_active,
  input  logic [FB_COORD_W-1:0] vga_x,
  input  logic [FB_COORD_W-1:0] vga_y,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow
);

  // One extra bit so the counter can represent "frame full"
  localparam int                 c_cnt_w  = ADDR_W + 1;
  localparam logic [c_cnt_w-1:0] c_pixels = c_cnt_w'(FRAME_W * FRAME_H);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_last   = c_pixels - c_one;

  fb_state_e          state_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [7:0]         wr_data_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               overflow_q;
  logic               cap_en_q;

  logic               w_go_clear;
  logic               w_new_frame;
  logic               w_cnt_full;
  logic               w_cap_rise;
  logic               w_last_written;
  logic [7:0]         w_px_data;
  logic [7:0]         w_px0_data;

`ifdef FB_TEST_PATTERN_EN
  logic [7:0]         frame_cnt_q;

  // Pattern data: current pixel index mixed with the completed-frame count
  always_comb begin
    w_px_data  = cnt_q[7:0] ^ frame_cnt_q;
    w_px0_data = frame_cnt_q;
  end

  // Count completed frames so consecutive captures look different
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) frame_cnt_q <= 8'd0;
    else if (w_last_written) frame_cnt_q <= frame_cnt_q + 8'd1;
  end
`else
  // Camera bytes go straight to the RAM
  always_comb begin
    w_px_data  = cam_data;
    w_px0_data = cam_data;
  end
`endif

  // Decode events that override the per-state behaviour
  always_comb begin
    // start restarts the clear from anywhere except an ongoing clear
    w_go_clear     = start && (state_q != ST_CLEAR);
    // VSYNC opens a frame when waiting, or restarts it while capture continues
    w_new_frame    = cam_frame_start &&
                     ((state_q == ST_WAIT_SOF) || ((state_q == ST_CAPTURE) && capture_en));
    w_cnt_full     = (cnt_q == c_pixels);
    w_cap_rise     = capture_en && !cap_en_q;
    // The last pixel of a frame was written on the previous edge
    w_last_written = (state_q == ST_CAPTURE) && wr_en_q &&
                     (wr_addr_q == c_last[ADDR_W-1:0]);
  end

  // Sequencer: state, write port, status flags, all registered
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      cap_en_q     <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= w_last_written;
      cap_en_q     <= capture_en;

      if (w_go_clear) begin
        // First clear write goes out on the very next cycle at address 0
        state_q    <= ST_CLEAR;
        busy_q     <= 1'b1;
        overflow_q <= 1'b0;
        wr_en_q    <= 1'b1;
        wr_addr_q  <= '0;
        wr_data_q  <= CLEAR_VALUE;
        cnt_q      <= c_one;
      end else if (w_new_frame) begin
        // Counter resets first, so a coincident pixel lands at address 0
        state_q <= ST_CAPTURE;
        busy_q  <= 1'b1;
        if (cam_valid) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= '0;
          wr_data_q <= w_px0_data;
          cnt_q     <= c_one;
        end else begin
          cnt_q     <= '0;
        end
      end else begin
        case (state_q)
          ST_CLEAR: begin
            if (w_cnt_full) begin
              state_q <= ST_WAIT_SOF;
            end else begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cnt_q[ADDR_W-1:0];
              wr_data_q <= CLEAR_VALUE;
              cnt_q     <= cnt_q + c_one;
            end
          end
          ST_CAPTURE: begin
            if (cam_frame_start) begin
              // capture_en low at VSYNC: keep the last frame
              state_q <= ST_HOLD;
              busy_q  <= 1'b0;
            end else if (cam_valid) begin
              if (w_cnt_full) begin
                overflow_q <= 1'b1;
              end else begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= cnt_q[ADDR_W-1:0];
                wr_data_q <= w_px_data;
                cnt_q     <= cnt_q + c_one;
              end
            end
          end
          ST_HOLD: begin
            if (w_cap_rise) begin
              state_q <= ST_WAIT_SOF;
              busy_q  <= 1'b1;
            end
          end
          ST_IDLE, ST_WAIT_SOF: begin
            // Nothing to do until start or VSYNC, both handled above
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  fb_rd_addr_gen #(
    .FRAME_W  (FRAME_W),
    .FRAME_H  (FRAME_H),
    .ADDR_W   (ADDR_W),
    .H_OFFSET (H_OFFSET),
    .V_OFFSET (V_OFFSET)
  ) u_rd_addr_gen (
    .clk_i        (CLOCK_50),
    .rst_ni       (reset_n),
    .vga_active_i (vga_active),
    .vga_x_i      (vga_x),
    .vga_y_i      (vga_y),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr)
  );

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_scheduler
// Description : Self-checking bench for fb_scheduler on a reduced 16x8 frame.
//               Expected RAM writes are queued as stimulus is driven and
//               popped by a write monitor; control flags checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_scheduler;

  localparam int         W    = 16;
  localparam int         H    = 8;
  localparam int         AW   = 8;
  localparam int         NPIX = W * H;
  localparam logic [7:0] CLR  = 8'd244;
  localparam int         HO   = 144;
  localparam int         VO   = 35;
`ifdef FB_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n, start, capture_en, cam_frame_start, cam_valid;
  logic [7:0]    cam_data;
  logic          vga_active;
  logic [10:0]   vga_x, vga_y;
  logic          wr_en, rd_en, busy, frame_done, overflow;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  model_fc = 0;

  fb_scheduler #(
    .FRAME_W(W), .FRAME_H(H), .ADDR_W(AW), .CLEAR_VALUE(CLR),
    .H_OFFSET(HO), .V_OFFSET(VO)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start),
    .capture_en(capture_en), .cam_frame_start(cam_frame_start),
    .cam_valid(cam_valid), .cam_data(cam_data), .vga_active(vga_active),
    .vga_x(vga_x), .vga_y(vga_y), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .busy(busy),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Write monitor: every RAM write must match the oldest queued expectation
  always @(negedge CLOCK_50) begin
    if (reset_n === 1'b1 && wr_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%0d, required no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL write_stream: addr=%0d data=%0d, required addr=%0d data=%0d",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] exp_pix(input int addr, input logic [7:0] d);
    return TP ? (8'(addr) ^ 8'(model_fc)) : d;
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_clear();
    for (int k = 0; k < NPIX; k++) exp_q.push_back('{addr: AW'(k), data: CLR});
  endtask

  // Pixels at addresses first.. ; those past the frame are expected dropped
  task automatic send_pixels(input int first, input int count);
    logic [7:0] d;
    for (int k = 0; k < count; k++) begin
      if (k % 7 == 6) begin
        cam_valid = 1'b0;
        tick();
      end
      d         = 8'($urandom);
      cam_valid = 1'b1;
      cam_data  = d;
      if (first + k < NPIX) exp_q.push_back('{addr: AW'(first + k), data: exp_pix(first + k, d)});
      tick();
    end
    cam_valid = 1'b0;
  endtask

  // Called one cycle after the final pixel was driven
  task automatic check_frame_done_pulse(input string tag);
    @(negedge CLOCK_50);
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_early: frame_done=%b, required 0", tag, frame_done); end
    tick();
    @(negedge CLOCK_50);
    n_checks++;
    if (frame_done !== 1'b1) begin n_fail++; $display("FAIL %s_done_pulse: frame_done=%b, required 1", tag, frame_done); end
    tick();
    @(negedge CLOCK_50);
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_width: frame_done=%b, required 0", tag, frame_done); end
    model_fc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; capture_en = 1'b1; cam_frame_start = 1'b0;
    cam_valid = 1'b0; cam_data = 8'd0; vga_active = 1'b0; vga_x = '0; vga_y = '0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    n_checks++; if (wr_en !== 1'b0)      begin n_fail++; $display("FAIL reset_wr_en: %b, required 0", wr_en); end
    n_checks++; if (wr_addr !== '0)      begin n_fail++; $display("FAIL reset_wr_addr: %0d, required 0", wr_addr); end
    n_checks++; if (wr_data !== 8'd0)    begin n_fail++; $display("FAIL reset_wr_data: %0d, required 0", wr_data); end
    n_checks++; if (rd_en !== 1'b0)      begin n_fail++; $display("FAIL reset_rd_en: %b, required 0", rd_en); end
    n_checks++; if (rd_addr !== '0)      begin n_fail++; $display("FAIL reset_rd_addr: %0d, required 0", rd_addr); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: %b, required 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: %b, required 0", frame_done); end
    n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: %b, required 0", overflow); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Clear ignores start and camera inputs; WAIT_SOF follows the last write
  task automatic test_clear();
    start = 1'b1;
    push_clear();
    tick();
    start = 1'b0;
    @(negedge CLOCK_50);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy: %b, required 1", busy); end
    repeat (48) tick();
    start = 1'b1; cam_frame_start = 1'b1; cam_valid = 1'b1; cam_data = 8'h55;
    tick();
    start = 1'b0; cam_frame_start = 1'b0; cam_valid = 1'b0;
    repeat (79) tick();
    @(negedge CLOCK_50);
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL clear_end_wr_en: %b, required 0", wr_en); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_sof_busy: %b, required 1", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clear_count: %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_wait_sof();
    for (int k = 0; k < 5; k++) begin
      cam_valid = 1'b1; cam_data = 8'(k + 1);
      tick();
      @(negedge CLOCK_50);
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL wait_sof_write: wr_en=%b, required 0", wr_en); end
    end
    cam_valid = 1'b0;
    tick();
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    send_pixels(0, NPIX);
    check_frame_done_pulse("frame1");
  endtask

  task automatic test_overflow();
    tick();
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    send_pixels(0, NPIX);
    check_frame_done_pulse("frame2");
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_early: %b, required 0", overflow); end
    tick();
    send_pixels(NPIX, 5);
    @(negedge CLOCK_50);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: %b, required 1", overflow); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL overflow_done: %b, required 0", frame_done); end
    tick();
    // VSYNC coinciding with a pixel: pixel lands at address 0
    cam_frame_start = 1'b1; cam_valid = 1'b1; cam_data = 8'hA5;
    exp_q.push_back('{addr: AW'(0), data: exp_pix(0, 8'hA5)});
    tick();
    cam_frame_start = 1'b0; cam_valid = 1'b0;
    send_pixels(1, 9);
    @(negedge CLOCK_50);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: %b, required 1", overflow); end
  endtask

  task automatic test_short_frame();
    tick();
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    send_pixels(0, 4);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL short_frame_done: %b, required 0", frame_done); end
      tick();
    end
  endtask

  task automatic test_hold();
    capture_en = 1'b0;
    cam_frame_start = 1'b1; cam_valid = 1'b1; cam_data = 8'h11;
    tick();
    cam_frame_start = 1'b0; cam_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK_50);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy: %b, required 0", busy); end
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL hold_write: %b, required 0", wr_en); end
      tick();
      cam_valid = 1'b1; cam_frame_start = (k == 1); cam_data = 8'(k);
    end
    cam_valid = 1'b0; cam_frame_start = 1'b0;
    tick();
    capture_en = 1'b1;
    tick();
    @(negedge CLOCK_50);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_resume_busy: %b, required 1", busy); end
    tick();
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    send_pixels(0, 3);
  endtask

  // start mid-capture restarts clearing at address 0 and clears overflow
  task automatic test_abort();
    send_pixels(3, 37);
    start = 1'b1; cam_valid = 1'b1; cam_data = 8'h77;
    push_clear();
    tick();
    start = 1'b0; cam_valid = 1'b0;
    @(negedge CLOCK_50);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL abort_overflow: %b, required 0", overflow); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: %b, required 1", busy); end
    repeat (128) tick();
    @(negedge CLOCK_50);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_clear_count: %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_read();
    int xs[12] = '{144, 159, 150, 200, 144, 159, 144, 0, 0, 0, 0, 151};
    int ys[12] = '{35,  42,  37,  40,  43,  35,  42,  0, 0, 0, 0, 36};
    bit act[12] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int exp_addr, prev_addr, e;
    bit prev_en;
    prev_addr = 0; prev_en = 1'b0; exp_addr = 0;
    for (int i = 7; i < 11; i++) begin
      xs[i] = HO + int'($urandom_range(W - 1));
      ys[i] = VO + int'($urandom_range(H - 1));
    end
    for (int i = 0; i <= 12; i++) begin
      tick();
      if (i < 12) begin
        vga_active = act[i]; vga_x = 11'(xs[i]); vga_y = 11'(ys[i]);
      end
      @(negedge CLOCK_50);
      if (i > 0) begin
        n_checks++;
        if (rd_en !== prev_en || rd_addr !== AW'(prev_addr)) begin
          n_fail++;
          $display("FAIL read_addr[%0d]: rd_en=%b rd_addr=%0d, required rd_en=%b rd_addr=%0d",
                   i - 1, rd_en, rd_addr, prev_en, prev_addr);
        end
      end
      if (i < 12) begin
        if (act[i]) begin
          e = (ys[i] - VO) * W + (xs[i] - HO);
          exp_addr = (e >= NPIX || e < 0) ? 0 : e;
        end
        prev_addr = exp_addr;
        prev_en   = act[i];
      end
    end
  endtask

  // Asynchronous reset mid-clear returns outputs to reset values at once
  task automatic test_async_reset();
    tick();
    start = 1'b1;
    push_clear();
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL async_wr_en: %b, required 0", wr_en); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL async_busy: %b, required 0", busy); end
    n_checks++; if (wr_addr !== '0)    begin n_fail++; $display("FAIL async_wr_addr: %0d, required 0", wr_addr); end
    n_checks++; if (rd_en !== 1'b0)    begin n_fail++; $display("FAIL async_rd_en: %b, required 0", rd_en); end
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    @(negedge CLOCK_50);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy=%b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_wait_sof();
    test_overflow();
    test_short_frame();
    test_hold();
    test_abort();
    test_read();
    test_async_reset();
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue: %0d writes outstanding, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
